axi_mm_chkr_seq: RTL
====================

AXI_MM_CHKR_SEQ -- requirements
Module: axi_mm_chkr_seq

Interface
REQ-001 Parameter: CNT_W, default 16, width of run, timer and result counters.
REQ-002 Parameter: GAP_CYC, default 16, idle cycles between consecutive burst runs (min 1).
REQ-003 Port: rdclk  in  1  clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: start  in  1  one-cycle request to begin a test campaign.
REQ-006 Port: cont_mode  in  1  0 = burst campaign, 1 = single continuous-pattern run; sampled with start.
REQ-007 Port: num_runs  in  CNT_W  burst runs per campaign; sampled with start.
REQ-008 Port: timeout_cyc  in  CNT_W  per-run result timeout in cycles; 0 disables timeout; sampled with start.
REQ-009 Port: stop  in  1  ends the continuous run.
REQ-010 Port: patchkr_out  in  2  checker result: 00 pending, 11 pass, 10 fail, 01 treated as fail.
REQ-011 Port: patchkr_en  out  1  one-cycle pulse launching one burst check.
REQ-012 Port: cntuspatt_en  out  1  level, high for the duration of a continuous run.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.
REQ-014 Port: done  out  1  one-cycle pulse at campaign end.
REQ-015 Port: overall_pass  out  1  campaign verdict, valid from done until the next start.
REQ-016 Port: pass_cnt, fail_cnt, tout_cnt  out  CNT_W each  per-campaign result counters.

Function
REQ-017 States: IDLE, LAUNCH, ARM, CONT, WAIT, GAP, DONE.
REQ-018 IDLE: start=1 latches cont_mode, num_runs (0 latched as 1), timeout_cyc; clears all three counters, run index, timer and overall_pass; next state LAUNCH.
REQ-019 start while busy=1 is ignored.
REQ-020 LAUNCH (1 cycle): burst mode drives patchkr_en=1 for this cycle only; continuous mode sets cntuspatt_en=1; clears timer; next state ARM.
REQ-021 ARM: waits for patchkr_out==00, discarding any stale result from the previous run; next state CONT (continuous) or WAIT (burst).
REQ-022 CONT: holds cntuspatt_en=1; stop=1 clears cntuspatt_en the next cycle; next state WAIT. Timer does not run in CONT.
REQ-023 stop outside CONT is ignored, including stop in ARM.
REQ-024 Timer: increments once per cycle in ARM and WAIT, saturates at all-ones, clears in LAUNCH.
REQ-025 WAIT: on the first cycle patchkr_out!=00: 11 increments pass_cnt; 10 or 01 increments fail_cnt; next state GAP.
REQ-026 Timeout: timeout_cyc!=0 and timer==timeout_cyc in ARM or WAIT increments tout_cnt; next state GAP.
REQ-027 Result and timeout in the same cycle: the result is recorded and the timeout is not.
REQ-028 GAP: waits GAP_CYC cycles; then if run_index+1 < latched num_runs, increments run_index and goes to LAUNCH, else goes to DONE. Continuous mode always goes to DONE.
REQ-029 DONE (1 cycle): done=1; overall_pass=1 iff fail_cnt==0, tout_cnt==0 and pass_cnt!=0; next state IDLE.
REQ-030 All counters saturate at all-ones and never wrap.
REQ-031 Counters and overall_pass hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n=0 at any point, including mid-campaign, forces IDLE next edge: patchkr_en=0, cntuspatt_en=0, busy=0, done=0, overall_pass=0, all counters 0, timer 0, run index 0.
REQ-033 No output glitches or pulses are produced on reset exit.

Verification
REQ-034 Burst, num_runs=3, timeout=0, checker model returns 11 each run -> exactly 3 single-cycle patchkr_en pulses spaced by at least GAP_CYC cycles; pass_cnt=3, fail_cnt=0; done pulse; overall_pass=1.
REQ-035 Burst, num_runs=2, run 2 returns 10 -> pass_cnt=1, fail_cnt=1, overall_pass=0.
REQ-036 Burst, num_runs=1, timeout_cyc=50, patchkr_out held 00 -> tout_cnt=1 exactly 50 cycles after ARM entry; overall_pass=0.
REQ-037 Continuous mode, stop after 200 cycles, checker returns 11 -> cntuspatt_en high from LAUNCH+1 until the cycle after stop; pass_cnt=1; no patchkr_en pulse.
REQ-038 num_runs=0 with start -> exactly one run executes; start pulsed mid-campaign -> ignored; rst_n=0 mid-WAIT -> all outputs 0 on the next cycle.
REQ-039 Stale patchkr_out=11 at launch -> not counted until patchkr_out has returned to 00 and then gone nonzero.

Source files
------------

// File: rtl/axi_mm_chkr_seq.sv
// axi_mm_chkr_seq: sequences pattern-checker test campaigns.
// Burst mode launches num_runs single checks separated by idle gaps.
// Continuous mode holds one continuous-pattern run open until stop.
// Each run records one outcome: pass, fail or timeout.
module axi_mm_chkr_seq #(
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 16
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic [CNT_W-1:0] num_runs,
  input  logic [CNT_W-1:0] timeout_cyc,
  input  logic             stop,
  input  logic [1:0]       patchkr_out,
  output logic             patchkr_en,
  output logic             cntuspatt_en,
  output logic             busy,
  output logic             done,
  output logic             overall_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tout_cnt
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, LAUNCH, ARM, CONT, WAIT, GAP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   runs_q, runs_d;
  logic [CNT_W-1:0]   tout_lim_q, tout_lim_d;
  logic [CNT_W-1:0]   run_idx_q, run_idx_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]   tout_q, tout_d;
  logic               op_q, op_d;
  logic               cntus_q, cntus_d;

  logic               result_vld;
  logic               tout_hit;
  logic [CNT_W:0]     run_next;
  logic               more_runs;

  // Saturating increment shared by every counter so none can wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Next-state and datapath logic for the campaign sequencer.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    runs_d     = runs_q;
    tout_lim_d = tout_lim_q;
    run_idx_d  = run_idx_q;
    timer_d    = timer_q;
    gap_d      = '0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tout_d     = tout_q;
    op_d       = op_q;

    result_vld = (patchkr_out != 2'b00);
    tout_hit   = (tout_lim_q != '0) && (timer_q == tout_lim_q);
    run_next   = {1'b0, run_idx_q} + {1'b0, CNT_ONE};
    more_runs  = (run_next < {1'b0, runs_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = cont_mode;
          runs_d     = (num_runs == '0) ? CNT_ONE : num_runs;
          tout_lim_d = timeout_cyc;
          pass_d     = '0;
          fail_d     = '0;
          tout_d     = '0;
          run_idx_d  = '0;
          timer_d    = '0;
          op_d       = 1'b0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = ARM;
      end
      ARM: begin
        timer_d = sat_inc(timer_q);
        if (tout_hit) begin
          tout_d  = sat_inc(tout_q);
          state_d = GAP;
        end else if (!result_vld) begin
          state_d = mode_q ? CONT : WAIT;
        end
      end
      CONT: begin
        if (stop) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = sat_inc(timer_q);
        if (result_vld) begin
          if (patchkr_out == 2'b11) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
          end
          state_d = GAP;
        end else if (tout_hit) begin
          tout_d  = sat_inc(tout_q);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (!mode_q && more_runs) begin
            run_idx_d = run_next[CNT_W-1:0];
            state_d   = LAUNCH;
          end else begin
            op_d    = (fail_q == '0) && (tout_q == '0) && (pass_q != '0);
            state_d = DONE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cntus_d = mode_q && ((state_d == ARM) || (state_d == CONT));
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      runs_q     <= '0;
      tout_lim_q <= '0;
      run_idx_q  <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      tout_q     <= '0;
      op_q       <= 1'b0;
      cntus_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      runs_q     <= runs_d;
      tout_lim_q <= tout_lim_d;
      run_idx_q  <= run_idx_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tout_q     <= tout_d;
      op_q       <= op_d;
      cntus_q    <= cntus_d;
    end
  end

  assign patchkr_en   = (state_q == LAUNCH) && !mode_q;
  assign cntuspatt_en = cntus_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign overall_pass = op_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign tout_cnt     = tout_q;

endmodule
